// File: rtl/axi_mem_responder.sv
// AXI4 memory responder: dual-port word array with independent single-outstanding
// write (AW/W/B) and read (AR/R) burst engines; the read data path is registered.
module axi_mem_responder #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 256,
  parameter int MEM_DEPTH  = 8192
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int WORD_LSB = $clog2(STRB_W);
  localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [2:0]            FULL_SIZE   = 3'(WORD_LSB);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A     = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(MEM_DEPTH - 1);
  localparam logic [1:0]            BURST_FIXED = 2'b00;
  localparam logic [1:0]            BURST_RSVD  = 2'b11;
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] word;
    word = (addr >> WORD_LSB) % DEPTH_A;
    return IDX_W'(word);
  endfunction

  function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx,
                                                 input logic [1:0]       burst);
    if (burst == BURST_FIXED) return idx;
    if (idx == LAST_IDX)      return '0;
    return idx + IDX_W'(1);
  endfunction

  function automatic logic burst_error(input logic [2:0] size, input logic [1:0] burst);
    return (size != FULL_SIZE) || (burst == BURST_RSVD);
  endfunction

  // ---------------------------------------------------------------- write path
  w_state_e         w_state_q, w_state_d;
  logic [IDX_W-1:0] w_idx_q, w_idx_d;
  logic [7:0]       w_len_q, w_len_d;
  logic [7:0]       w_beat_q, w_beat_d;
  logic [1:0]       w_burst_q, w_burst_d;
  logic             w_err_q, w_err_d;
  logic             aw_hs, w_hs, b_hs, w_final;

  assign s_axi_awready = !reset && (w_state_q == W_IDLE);
  assign s_axi_wready  = !reset && (w_state_q == W_DATA);
  assign s_axi_bvalid  = !reset && (w_state_q == W_RESP);
  assign s_axi_bresp   = (s_axi_bvalid && w_err_q) ? RESP_SLVERR : RESP_OKAY;

  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign b_hs    = s_axi_bvalid && s_axi_bready;
  assign w_final = (w_beat_q == w_len_q);

  // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_burst_d = w_burst_q;
    w_err_d   = w_err_q;
    unique case (w_state_q)
      W_IDLE: if (aw_hs) begin
        w_idx_d   = word_index(s_axi_awaddr);
        w_len_d   = s_axi_awlen;
        w_burst_d = s_axi_awburst;
        w_beat_d  = '0;
        w_err_d   = burst_error(s_axi_awsize, s_axi_awburst);
        w_state_d = W_DATA;
      end
      W_DATA: if (w_hs) begin
        if (s_axi_wlast != w_final) w_err_d = 1'b1;
        if (w_final) begin
          w_state_d = W_RESP;
        end else begin
          w_beat_d = w_beat_q + 8'd1;
          w_idx_d  = next_index(w_idx_q, w_burst_q);
        end
      end
      W_RESP: if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_burst_q <= w_burst_d;
      w_err_q   <= w_err_d;
    end
  end

  // ---------------------------------------------------------------- storage
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // NOTE: the array has no reset; its contents must survive a reset and it maps onto RAM.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem_q[w_idx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- read path
  r_state_e              r_state_q, r_state_d;
  logic [IDX_W-1:0]      r_idx_q, r_idx_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [7:0]            r_beat_q, r_beat_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic                  r_err_q, r_err_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  ar_hs, r_hs, rd_en;

  assign s_axi_arready = !reset && (r_state_q == R_IDLE);
  assign s_axi_rvalid  = !reset && (r_state_q == R_DATA);
  assign s_axi_rlast   = s_axi_rvalid && (r_beat_q == r_len_q);
  assign s_axi_rresp   = (s_axi_rvalid && r_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_rdata   = reset ? '0 : rdata_q;

  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_hs  = s_axi_rvalid && s_axi_rready;

  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_burst_d = r_burst_q;
    r_err_d   = r_err_q;
    rd_en     = 1'b0;
    unique case (r_state_q)
      R_IDLE: if (ar_hs) begin
        r_idx_d   = word_index(s_axi_araddr);
        r_len_d   = s_axi_arlen;
        r_burst_d = s_axi_arburst;
        r_beat_d  = '0;
        r_err_d   = burst_error(s_axi_arsize, s_axi_arburst);
        r_state_d = R_FETCH;
      end
      R_FETCH: begin
        rd_en     = 1'b1;
        r_state_d = R_DATA;
      end
      R_DATA: if (r_hs) begin
        if (s_axi_rlast) begin
          r_state_d = R_IDLE;
        end else begin
          // Prefetch the next beat on the accepting edge so beats stream without bubbles.
          rd_en    = 1'b1;
          r_beat_d = r_beat_q + 8'd1;
          r_idx_d  = next_index(r_idx_q, r_burst_q);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_burst_q <= '0;
      r_err_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_burst_q <= r_burst_d;
      r_err_q   <= r_err_d;
      // Same-edge write to this word is not yet visible, giving read-first behaviour.
      if (rd_en) rdata_q <= mem_q[r_idx_d];
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder: bursts, strobes, backpressure,
// response errors, index wrap and mid-burst reset, with hand-computed expectations.
module tb_axi_mem_responder;

  localparam int AW = 18;
  localparam int DW = 256;
  localparam int SW = DW / 8;
  localparam logic [2:0] SZ = 3'd5;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst;
  logic          awvalid, awready, arvalid, arready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic          wlast, wvalid, wready;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, rlast, rvalid, rready;

  axi_mem_responder dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] wb_data [16];
  logic [SW-1:0] wb_strb [16];
  logic [DW-1:0] rd_data [16];
  logic [1:0]    rd_resp [16];
  logic          rd_last [16];
  int            rd_count, rd_lat, rd_span;
  logic [1:0]    resp;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got no handshake expected one within the cycle budget", tag);
  endtask

  task automatic write_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size,
                             input int bad_beat, output logic [1:0] b);
    int t;
    b = 2'bxx;
    @(negedge clk);
    awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    if (!awready) timeout_fail("aw_wait");
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wb_data[i]; wstrb = wb_strb[i]; wvalid = 1'b1;
      wlast = (bad_beat >= 0) ? (i == bad_beat) : (i == int'(len));
      t = 0;
      while (!wready && t < 50) begin @(negedge clk); t++; end
      if (!wready) timeout_fail("w_wait");
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    t = 0;
    while (!bvalid && t < 50) begin @(negedge clk); t++; end
    if (!bvalid) timeout_fail("b_wait");
    b = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  // mode 0: rready held high; mode 1: rready pattern 1,0,0 repeating.
  task automatic read_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input int mode);
    int t, k, ar_cyc, first_hs, last_hs;
    logic prev_stall, prev_last;
    logic [DW-1:0] prev_data;
    @(negedge clk);
    araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    if (!arready) timeout_fail("ar_wait");
    ar_cyc = cyc;
    @(negedge clk);
    arvalid = 1'b0;
    rd_count = 0; rd_lat = -1; first_hs = 0; last_hs = 0;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    k = 0; t = 0;
    while (rd_count <= int'(len) && t < 300) begin
      rready = (mode == 0) || (k % 3 == 0);
      if (prev_stall) begin
        check("r_stall_valid", rvalid, 1'b1);
        check("r_stall_data", rdata, prev_data);
        check("r_stall_last", rlast, prev_last);
      end
      if (rvalid) begin
        if (rd_lat < 0) rd_lat = cyc - ar_cyc;
        if (rready) begin
          rd_data[rd_count] = rdata; rd_resp[rd_count] = rresp; rd_last[rd_count] = rlast;
          if (rd_count == 0) first_hs = cyc;
          last_hs = cyc;
          rd_count++;
        end
      end
      prev_stall = rvalid && !rready; prev_data = rdata; prev_last = rlast;
      k++; t++;
      @(negedge clk);
    end
    rready = 1'b0;
    if (rd_count <= int'(len)) timeout_fail("r_beats");
    rd_span = last_hs - first_hs;
    check("r_done_idle", {rvalid, arready}, 2'b01);
  endtask

  initial begin
    int t, hs;
    logic seen_b;
    reset = 1'b1;
    awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 16; i++) begin wb_data[i] = '0; wb_strb[i] = '1; end

    repeat (3) @(negedge clk);
    check("rst_ready", {awready, wready, arready}, 3'b000);
    check("rst_valid", {bvalid, rvalid, rlast}, 3'b000);
    check("rst_resp", {bresp, rresp}, 4'b0000);
    check("rst_rdata", rdata, '0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {awready, arready}, 2'b11);

    // INCR burst write then read back, latency and last-beat marking
    for (int i = 0; i < 4; i++) wb_data[i] = 256'hA0 + 256'(i);
    write_burst(18'h00040, 8'd3, 2'b01, SZ, -1, resp);
    check("incr_bresp", resp, 2'b00);
    read_burst(18'h00040, 8'd3, 2'b01, SZ, 0);
    for (int i = 0; i < 4; i++) begin
      check("incr_rdata", rd_data[i], 256'hA0 + 256'(i));
      check("incr_rlast", rd_last[i], (i == 3));
      check("incr_rresp", rd_resp[i], 2'b00);
    end
    check("incr_latency", rd_lat, 2);
    check("incr_no_bubble", rd_span, 3);

    // Byte strobes on a single-beat burst
    wb_data[0] = {32{8'h11}};
    write_burst(18'h00000, 8'd0, 2'b01, SZ, -1, resp);
    check("strb_bresp0", resp, 2'b00);
    wb_data[0] = {32{8'hFF}}; wb_strb[0] = 32'h0000_000F;
    write_burst(18'h00000, 8'd0, 2'b01, SZ, -1, resp);
    check("strb_bresp1", resp, 2'b00);
    wb_strb[0] = '1;
    read_burst(18'h00000, 8'd0, 2'b01, SZ, 0);
    check("strb_rdata", rd_data[0], {{28{8'h11}}, {4{8'hFF}}});
    check("single_rlast", rd_last[0], 1'b1);

    // Eight-beat read under rready backpressure
    for (int i = 0; i < 8; i++) wb_data[i] = 256'hB0 + 256'(i);
    write_burst(18'h01000, 8'd7, 2'b01, SZ, -1, resp);
    check("bp_bresp", resp, 2'b00);
    read_burst(18'h01000, 8'd7, 2'b01, SZ, 1);
    check("bp_count", rd_count, 8);
    for (int i = 0; i < 8; i++) begin
      check("bp_rdata", rd_data[i], 256'hB0 + 256'(i));
      check("bp_rlast", rd_last[i], (i == 7));
    end

    // Early wlast gives SLVERR but both beats land
    wb_data[0] = 256'hC0; wb_data[1] = 256'hC1;
    write_burst(18'h00200, 8'd1, 2'b01, SZ, 0, resp);
    check("wlast_bresp", resp, 2'b10);
    read_burst(18'h00200, 8'd1, 2'b01, SZ, 0);
    check("wlast_beat0", rd_data[0], 256'hC0);
    check("wlast_beat1", rd_data[1], 256'hC1);

    // FIXED burst keeps overwriting the start word only
    wb_data[0] = 256'hEE; wb_data[1] = 256'hEF;
    write_burst(18'h00300, 8'd1, 2'b01, SZ, -1, resp);
    wb_data[0] = 256'hD0; wb_data[1] = 256'hD1; wb_data[2] = 256'hD2;
    write_burst(18'h00300, 8'd2, 2'b00, SZ, -1, resp);
    check("fixed_bresp", resp, 2'b00);
    read_burst(18'h00300, 8'd1, 2'b01, SZ, 0);
    check("fixed_start", rd_data[0], 256'hD2);
    check("fixed_next", rd_data[1], 256'hEF);

    // Descriptor errors: narrow read size, reserved write burst type
    read_burst(18'h00040, 8'd0, 2'b01, 3'd4, 0);
    check("size_rresp", rd_resp[0], 2'b10);
    wb_data[0] = 256'h99;
    write_burst(18'h00600, 8'd0, 2'b11, SZ, -1, resp);
    check("rsvd_bresp", resp, 2'b10);

    // Index wraps from the top word to word 0
    wb_data[0] = 256'hE0; wb_data[1] = 256'hE1;
    write_burst(18'h3FFE0, 8'd1, 2'b01, SZ, -1, resp);
    check("wrap_bresp", resp, 2'b00);
    read_burst(18'h3FFE0, 8'd1, 2'b01, SZ, 0);
    check("wrap_top", rd_data[0], 256'hE0);
    check("wrap_top_next", rd_data[1], 256'hE1);
    read_burst(18'h00000, 8'd0, 2'b01, SZ, 0);
    check("wrap_word0", rd_data[0], 256'hE1);

    // Reset while beat 2 of an 8-beat read is being presented
    @(negedge clk);
    araddr = 18'h01000; arlen = 8'd7; arsize = SZ; arburst = 2'b01; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    hs = 0; t = 0;
    while (hs < 2 && t < 50) begin
      if (rvalid) hs++;
      @(negedge clk);
      t++;
    end
    if (hs < 2) timeout_fail("rst_read_beats");
    check("pre_rst_beat2", rdata, 256'hB2);
    reset = 1'b1; rready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_abort_rvalid", rvalid, 1'b0);
    check("rst_abort_arready", arready, 1'b1);
    @(negedge clk);
    check("rst_abort_idle", {rvalid, rlast}, 2'b00);
    read_burst(18'h01000, 8'd7, 2'b01, SZ, 0);
    for (int i = 0; i < 8; i++) check("rst_mem_intact", rd_data[i], 256'hB0 + 256'(i));

    // Reset mid-write: no B response for the aborted burst
    @(negedge clk);
    awaddr = 18'h05000; awlen = 8'd3; awsize = SZ; awburst = 2'b01; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    awvalid = 1'b0; wdata = 256'h77; wstrb = '1; wlast = 1'b0; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; bready = 1'b1;
    seen_b = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bvalid) seen_b = 1'b1;
    end
    bready = 1'b0;
    check("abort_no_b", seen_b, 1'b0);
    check("abort_awready", awready, 1'b1);
    read_burst(18'h05000, 8'd0, 2'b01, SZ, 0);
    check("abort_beat_kept", rd_data[0], 256'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
